// File: rtl/add3_serial_sched.sv
// Round-robin sequencer for a shared external 3-bit adder slice: two request ports,
// digit-serial LSD-first addition with registered carry, one valid/ready response port.
module add3_serial_sched #(
  parameter  int NDIG = 4,
  localparam int W    = 3 * NDIG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic [2:0]   slice_a,
  output logic [2:0]   slice_b,
  output logic         slice_cin,
  input  logic [2:0]   slice_s,
  input  logic         slice_cout
);

  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIGW = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [KW-1:0]  k_q, k_d;
  logic           id_q, id_d;
  logic           last_grant_q, last_grant_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      k_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      k_q          <= k_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: accept on grant, one digit per RUN cycle, hold DONE until taken
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    k_d          = k_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d          = req1_ready ? req1_a : req0_a;
          b_d          = req1_ready ? req1_b : req0_b;
          carry_d      = req1_ready ? req1_cin : req0_cin;
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          k_d          = '0;
          sum_d        = '0;
          state_d      = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[DIGW*int'(k_q) +: DIGW] = slice_s;
        carry_d                       = slice_cout;
        if (k_q == KW'(NDIG - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: round-robin grant (only in IDLE, out of reset) and slice drive
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    slice_a    = 3'd0;
    slice_b    = 3'd0;
    slice_cin  = 1'b0;
    if (state_q == IDLE && rst_n) begin
      req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
      req0_ready = req0_valid & ~req1_ready;
    end else begin
      req1_ready = 1'b0;
      req0_ready = 1'b0;
    end
    if (state_q == RUN) begin
      slice_a   = a_q[DIGW*int'(k_q) +: DIGW];
      slice_b   = b_q[DIGW*int'(k_q) +: DIGW];
      slice_cin = carry_q;
    end else begin
      slice_a   = 3'd0;
      slice_b   = 3'd0;
      slice_cin = 1'b0;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: doc/add3_serial_sched.md
# add3_serial_sched

Sequencer and two-port arbiter for the shared 3-bit ripple-carry adder slice (a[2:0] + b[2:0] + cin -> s[2:0], cout). It accepts W = 3*NDIG-bit add requests from two requesters and grants them round-robin. Each granted operation is fed through the slice one 3-bit digit per cycle, least-significant digit first, with the carry registered between digits. The finished sum and carry-out are returned on a single valid/ready response port. The slice is external and purely combinational; this block drives its inputs and samples its outputs in the same cycle.

## Interface
- NDIG, 4, number of 3-bit digits per operand; W = 3*NDIG; NDIG >= 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready)
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- req0_cin / req1_cin  in  1  carry-in
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  W  sum, low W bits
- rsp_cout  out  1  final carry-out
- rsp_id  out  1  port that issued the request
- slice_a, slice_b  out  3  current digit to the adder slice
- slice_cin  out  1  carry into the slice
- slice_s  in  3  slice sum (combinational from slice_a/b/cin)
- slice_cout  in  1  slice carry-out

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- Registers:
  - a_reg, b_reg (W bits)
  - carry_reg
  - sum_reg (W bits)
  - k: digit index, clog2(NDIG) bits, minimum 1
  - id_reg
  - last_grant (1 bit, reset value 1, so port 0 wins the first tie)
- IDLE:
  - With one valid, that port is granted.
  - With both valid, the port != last_grant is granted.
  - reqX_ready = grant for port X, driven combinationally from valid and state. Only one ready is high at a time, and only in IDLE.
  - On handshake:
    - latch a, b, cin into a_reg, b_reg, carry_reg, and the port number into id_reg
    - set last_grant to the port number, k=0, sum_reg=0
    - move to RUN.
- RUN:
  - Slice drive: slice_a = a_reg[3k+2:3k], slice_b = b_reg[3k+2:3k], slice_cin = carry_reg.
  - Each edge: sum_reg[3k+2:3k] <= slice_s, carry_reg <= slice_cout, k <= k+1.
  - At k == NDIG-1 the edge moves to DONE instead of incrementing k.
- DONE:
  - rsp_valid = 1; rsp_sum = sum_reg; rsp_cout = carry_reg; rsp_id = id_reg.
  - All three response fields stay stable while rsp_ready is low.
  - When rsp_valid & rsp_ready: move to IDLE. Requests are not accepted in the DONE cycle.
- Outside RUN, slice_a, slice_b and slice_cin are driven to 0.
- Requests arriving during RUN or DONE wait. The requester must hold valid and data stable until ready.
- Reset at any point:
  - state = IDLE, all registers 0, last_grant = 1.
  - An in-flight operation is discarded with no response.

## Timing
- Reset values of all outputs are 0: req*_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, slice_*.
- Accept in cycle c:
  - RUN occupies cycles c+1 .. c+NDIG.
  - rsp_valid first high in cycle c+NDIG+1.
- Minimum issue interval is NDIG+2 cycles (accept, NDIG digits, DONE with rsp_ready high).
- There is no combinational path from req* inputs to slice_* or rsp_* outputs.
- The only combinational path is req*_valid -> req*_ready.
- Carry out of digit NDIG-1 becomes rsp_cout. Overflow beyond W bits appears only there.

## Test plan
(NDIG=4, W=12; bench models the slice as {cout,s} = a+b+cin.)
- Reset: hold rst_n low 3 cycles with random inputs -> all outputs 0, both ready low.
- Carry ripple: req0 a=12'hFFF, b=12'h001, cin=0, accepted cycle c -> slice_cin sequence 0,1,1,1 in c+1..c+4; rsp_valid in c+5; rsp_sum=12'h000, rsp_cout=1, rsp_id=0.
- Carry-in: req1 a=12'h555, b=12'h2AA, cin=1 -> first digit slice_a=5, slice_b=2, slice_cin=1; result rsp_sum=12'h800, rsp_cout=0, rsp_id=1.
- Arbitration: both ports valid continuously from reset with distinct operands -> grants alternate in the order 0,1,0,1. A port never gets ready twice in a row while the other is valid.
- Backpressure: rsp_ready held low 3 cycles after rsp_valid -> rsp_sum, rsp_cout and rsp_id stable, both req ready low. The next accept occurs only in the cycle after rsp_ready goes high.
- Reset mid-op: assert rst_n low when k=2 in RUN -> rsp_valid never asserts for that op. After release, the block accepts a new request and its result is correct.
